// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: size/state encodings and lane helpers shared by the data-memory arbiter
package dm_arbiter_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam int BYTE_LANE_SH = 3;
  localparam int HALF_LANE_SH = 4;
  typedef enum logic {S_IDLE = 1'b0, S_RMW_WR = 1'b1} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size[1] && off != 2'd0);
  endfunction
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: byte/half lane extraction with extension, or sub-word store merge
import dm_arbiter_pkg::*;
module dm_lane_unit #(
  parameter bit MERGE = 1'b0
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] res
);
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ext, mrg, mask, ins;
  // pick the addressed lane, extend it for loads or splice wdata into it for stores
  always_comb begin
    bsh = 5'(off) << BYTE_LANE_SH;
    hsh = 5'(off[1]) << HALF_LANE_SH;
    b = 8'(word >> bsh);
    h = 16'(word >> hsh);
    ext = size[1] ? word : size == SZ_HALF ? {{16{~uns & h[15]}}, h} : {{24{~uns & b[7]}}, b};
    mask = size == SZ_HALF ? 32'h0000_ffff << hsh : 32'h0000_00ff << bsh;
    ins = size == SZ_HALF ? {16'h0, wdata[15:0]} << hsh : {24'h0, wdata[7:0]} << bsh;
    mrg = size[1] ? wdata : (word & ~mask) | ins;
    res = MERGE ? mrg : ext;
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter with load extension and sub-word read-modify-write
import dm_arbiter_pkg::*;
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_uns,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_uns,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_t state, state_nx;
  logic last_gnt, any, sel, mis, sub, wr_word, done, done_port;
  logic s_we, s_uns, r_port;
  logic [1:0] s_size, r_size;
  logic [31:0] s_addr, s_wdata, ld_word, mg_word, done_rdata, r_word, r_wdata;
  logic [ADDR_W+1:0] r_addr;
  logic unused_addr_hi;

  assign unused_addr_hi = ^s_addr[31:ADDR_W+2];

  // arbitrate between ports and classify the winning access; grants only while idle and out of reset
  always_comb begin
    any = reset && state == S_IDLE && (m0_req || m1_req);
    sel = (m0_req && m1_req) ? (RR_EN && !last_gnt) : m1_req;
    s_we = sel ? m1_we : m0_we;
    s_size = sel ? m1_size : m0_size;
    s_uns = sel ? m1_uns : m0_uns;
    s_addr = sel ? m1_addr : m0_addr;
    s_wdata = sel ? m1_wdata : m0_wdata;
    mis = misaligned(s_size, s_addr[1:0]);
    sub = s_we && !mis && !s_size[1];
    wr_word = any && s_we && !mis && s_size[1];
  end

  dm_lane_unit #(.MERGE(1'b0)) u_load (
    .word(mem_rdata), .wdata(32'h0), .off(s_addr[1:0]), .size(s_size), .uns(s_uns), .res(ld_word)
  );

  dm_lane_unit #(.MERGE(1'b1)) u_merge (
    .word(r_word), .wdata(r_wdata), .off(r_addr[1:0]), .size(r_size), .uns(1'b0), .res(mg_word)
  );

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;

  // a granted sub-word store spends one extra cycle writing the merged word
  always_comb state_nx = (state == S_IDLE && any && sub) ? S_RMW_WR : S_IDLE;

  // grants and memory drive: the granted port in idle, the latched merge in RMW_WR
  always_comb begin
    m0_gnt = any && !sel;
    m1_gnt = any && sel;
    mem_we = state == S_RMW_WR || wr_word;
    mem_addr = state == S_RMW_WR ? r_addr[ADDR_W+1:2] : any ? s_addr[ADDR_W+1:2] : '0;
    mem_wdata = state == S_RMW_WR ? mg_word : wr_word ? s_wdata : '0;
  end

  // completion of this cycle's access, reported on the owning port next cycle
  always_comb begin
    done = (any && !sub) || state == S_RMW_WR;
    done_port = state == S_RMW_WR ? r_port : sel;
    done_rdata = (any && !s_we && !mis) ? ld_word : '0;
  end

  // round-robin memory of the last winner; port 0 wins the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_gnt <= 1'b1;
    else if (any) last_gnt <= sel;

  // hold the old word and store operands across the read-modify-write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_word <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_size <= SZ_BYTE;
      r_port <= 1'b0;
    end else if (state == S_IDLE && any && sub) begin
      r_word <= mem_rdata;
      r_addr <= s_addr[ADDR_W+1:0];
      r_wdata <= s_wdata;
      r_size <= s_size;
      r_port <= sel;
    end

  // registered completion pulse, load data and error per port
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_rvalid <= done && !done_port;
      m1_rvalid <= done && done_port;
      m0_err <= done && !done_port && any && mis;
      m1_err <= done && done_port && any && mis;
      m0_rdata <= (done && !done_port) ? done_rdata : '0;
      m1_rdata <= (done && done_port) ? done_rdata : '0;
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed bench with a transaction-level reference model
module tb_dm_arbiter;
  localparam bit RR = 1'b1;
  logic clk, reset;
  logic m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [1:0] m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  logic fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err, fp_mem_we;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_wdata;
  logic [9:0] fp_mem_addr;
  logic [31:0] tb_mem [1024];
  logic [31:0] ref_mem [1024];
  int total = 0, passed = 0;
  logic gwe, rmw_we;
  logic [9:0] gaddr;
  logic [31:0] rmw_wd;
  logic [1:0] rmw_g;

  dm_arbiter #(.ADDR_W(10), .RR_EN(RR)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.ADDR_W(10), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9e37_79b9 ^ 32'h5a5a_1234;
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz, input logic un);
    logic [7:0] by [4];
    int v;
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    if (sz >= 2) return w;
    if (sz == 1) begin
      v = int'(by[int'(off) + 1]) * 256 + int'(by[off]);
      return (un || v < 32768) ? 32'(v) : 32'(v - 65536);
    end
    v = int'(by[off]);
    return (un || v < 128) ? 32'(v) : 32'(v - 256);
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz);
    logic [7:0] by [4];
    for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
    by[off] = d[7:0];
    if (sz == 1) by[int'(off) + 1] = d[15:8];
    return {by[3], by[2], by[1], by[0]};
  endfunction

  assign mem_rdata = tb_mem[mem_addr];

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end
  end

  // reference model: decides each cycle which access happens and what every output must be
  initial begin
    logic pend, last_w, mis, we_, un;
    logic [9:0] pa, wa;
    logic [31:0] pw, a, d;
    logic [1:0] sz, ev, ee, ed, nv, ne, nd, av, ae;
    logic [31:0] er [2];
    logic [31:0] nr [2];
    logic [31:0] ar [2];
    int pp, w;
    pend = 0; last_w = 1; ev = 0; ee = 0; ed = 0; pp = 0; pa = 0; pw = 0;
    er[0] = 0; er[1] = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_ctl", {25'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we}, 0);
        chk("rst_addr", {22'd0, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        pend = 0; last_w = 1; ev = 0;
      end else begin
        av = {m1_rvalid, m0_rvalid};
        ae = {m1_err, m0_err};
        ar[0] = m0_rdata; ar[1] = m1_rdata;
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("rvalid%0d", p), {31'd0, av[p]}, {31'd0, ev[p]});
          if (ev[p]) chk($sformatf("err%0d", p), {31'd0, ae[p]}, {31'd0, ee[p]});
          if (ev[p] && ed[p]) chk($sformatf("rdata%0d", p), ar[p], er[p]);
        end
        nv = 0; ne = 0; nd = 0; nr[0] = 0; nr[1] = 0;
        if (pend) begin
          chk("rmw_gnt", {30'd0, m0_gnt, m1_gnt}, 0);
          chk("rmw_we", {31'd0, mem_we}, 1);
          chk("rmw_addr", {22'd0, mem_addr}, {22'd0, pa});
          chk("rmw_wdata", mem_wdata, pw);
          ref_mem[pa] = pw;
          pend = 0;
          nv[pp] = 1;
        end else begin
          w = -1;
          if (m0_req && m1_req) w = RR ? (last_w ? 0 : 1) : 0;
          else if (m0_req) w = 0;
          else if (m1_req) w = 1;
          chk("gnt", {30'd0, m0_gnt, m1_gnt}, {30'd0, w == 0, w == 1});
          if (w < 0) chk("idle_we", {31'd0, mem_we}, 0);
          else begin
            last_w = (w == 1);
            we_ = w == 1 ? m1_we : m0_we;
            sz = w == 1 ? m1_size : m0_size;
            un = w == 1 ? m1_uns : m0_uns;
            a = w == 1 ? m1_addr : m0_addr;
            d = w == 1 ? m1_wdata : m0_wdata;
            wa = a[11:2];
            mis = (sz == 1 && a[0]) || (sz >= 2 && a[1:0] != 0);
            chk("addr", {22'd0, mem_addr}, {22'd0, wa});
            if (mis || !we_) begin
              chk("ld_we", {31'd0, mem_we}, 0);
              nv[w] = 1; ne[w] = mis; nd[w] = 1;
              nr[w] = mis ? 32'h0 : ld_model(ref_mem[wa], a[1:0], sz, un);
            end else if (sz >= 2) begin
              chk("st_we", {31'd0, mem_we}, 1);
              chk("st_wdata", mem_wdata, d);
              ref_mem[wa] = d;
              nv[w] = 1;
            end else begin
              chk("sub_we", {31'd0, mem_we}, 0);
              pend = 1; pa = wa; pp = w;
              pw = st_merge(ref_mem[wa], d, a[1:0], sz);
            end
          end
        end
        ev = nv; ee = ne; ed = nd; er[0] = nr[0]; er[1] = nr[1];
      end
    end
  end

  task automatic drive(input int p, input logic rq, input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req = rq; m0_we = we; m0_size = sz; m0_uns = un; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = rq; m1_we = we; m1_size = sz; m1_uns = un; m1_addr = a; m1_wdata = d;
    end
  endtask

  task automatic xfer(input int p, input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output logic er);
    logic got;
    @(posedge clk); #1;
    drive(p, 1, we, sz, un, a, d);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p == 1 ? m1_gnt : m0_gnt;
    end
    chk("gnt_wait", {31'd0, got}, 1);
    gwe = mem_we; gaddr = mem_addr;
    @(posedge clk); #1;
    drive(p, 0, 0, 0, 0, 0, 0);
    rmw_we = mem_we; rmw_wd = mem_wdata; rmw_g = {m0_gnt, m1_gnt};
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      got = p == 1 ? m1_rvalid : m0_rvalid;
      if (!got) begin @(posedge clk); #1; end
    end
    chk("rvalid_wait", {31'd0, got}, 1);
    rd = p == 1 ? m1_rdata : m0_rdata;
    er = p == 1 ? m1_err : m0_err;
  endtask

  task automatic rand_txn(input int p);
    if ($urandom_range(0, 3) == 0) drive(p, 0, 0, 0, 0, 0, 0);
    else drive(p, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) << 12) | $urandom_range(0, 63), $urandom);
  endtask

  initial begin
    logic [31:0] rd;
    logic er, got, prev, g0, g1;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    xfer(0, 1, 2, 0, 32'h10, 32'h1234_5678, rd, er);
    chk("sw_we", {31'd0, gwe}, 1);
    chk("sw_addr", {22'd0, gaddr}, 4);
    xfer(0, 0, 2, 0, 32'h10, 0, rd, er);
    chk("lw_10", rd, 32'h1234_5678);
    xfer(0, 1, 0, 0, 32'h13, 32'h0000_00ab, rd, er);
    chk("sb_grant_we", {31'd0, gwe}, 0);
    chk("sb_rmw_we", {31'd0, rmw_we}, 1);
    chk("sb_rmw_wdata", rmw_wd, 32'hab34_5678);
    chk("sb_rmw_nognt", {30'd0, rmw_g}, 0);
    xfer(0, 1, 1, 0, 32'h12, 32'h1111_beef, rd, er);
    chk("sh_rmw_wdata", rmw_wd, 32'hbeef_5678);
    xfer(1, 0, 2, 0, 32'h1010, 0, rd, er);
    chk("lw_wrap", rd, 32'hbeef_5678);
    xfer(0, 1, 2, 0, 32'h20, 32'h8000_ff80, rd, er);
    xfer(0, 0, 0, 0, 32'h20, 0, rd, er);
    chk("lb_signed", rd, 32'hffff_ff80);
    xfer(0, 0, 0, 1, 32'h20, 0, rd, er);
    chk("lbu", rd, 32'h0000_0080);
    xfer(0, 0, 1, 0, 32'h22, 0, rd, er);
    chk("lh_signed", rd, 32'hffff_8000);
    xfer(1, 0, 1, 0, 32'h21, 0, rd, er);
    chk("mis_err", {31'd0, er}, 1);
    chk("mis_rdata", rd, 0);
    chk("mis_we", {31'd0, gwe}, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 2, 0, 32'h10, 0);
    drive(1, 1, 0, 2, 0, 32'h20, 0);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_one_gnt", {31'd0, m0_gnt ^ m1_gnt}, 1);
      if (i == 0) chk("rr_first_m0", {31'd0, m0_gnt}, 1);
      else chk("rr_alternate", {31'd0, m1_gnt}, {31'd0, !prev});
      prev = m1_gnt;
      chk("fp_m0_only", {30'd0, fp_m0_gnt, fp_m1_gnt}, 2);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    xfer(0, 1, 2, 0, 32'h30, 32'hcafe_f00d, rd, er);
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 0, 32'h30, 32'h55);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m0_gnt;
    end
    chk("rst_sb_gnt", {31'd0, got}, 1);
    @(posedge clk); #1;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_we", {31'd0, mem_we}, 0);
    chk("rst_mid_out", {29'd0, m0_rvalid, m0_gnt, m0_err}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    xfer(0, 0, 2, 0, 32'h30, 0, rd, er);
    chk("rst_word_kept", rd, 32'hcafe_f00d);
    chk("rst_mem_kept", tb_mem[12], 32'hcafe_f00d);
    @(posedge clk); #1;
    rand_txn(0);
    rand_txn(1);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      if (!m0_req || g0) rand_txn(0);
      if (!m1_req || g1) rand_txn(1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, word-wide data memory. The memory has a combinational read and a full-word synchronous write.
- Port 0 is the CPU MEM stage. Port 1 is the debug/DMA loader.
- Grants one access per cycle. Performs load byte/half extraction and sign/zero extension.
- Converts sub-word stores into a two-cycle read-modify-write, because the memory accepts only full-word writes.

Parameters:
ADDR_W, 10, word-address width driven to memory (memory depth 2**ADDR_W words)
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
m0_req  in  1  port 0 request, held until m0_gnt
m0_we  in  1  port 0 store (1) / load (0)
m0_size  in  2  0 byte, 1 half, 2 word; 3 treated as word
m0_uns  in  1  load zero-extend (1) / sign-extend (0)
m0_addr  in  32  port 0 byte address
m0_wdata  in  32  port 0 store data, right-aligned
m0_gnt  out  1  request accepted this cycle
m0_rvalid  out  1  completion pulse, one cycle after gnt (two for sub-word store)
m0_rdata  out  32  extended load data, valid with m0_rvalid
m0_err  out  1  misaligned access, valid with m0_rvalid
m1_*  same set as m0_*, for port 1
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read of mem_addr

Behaviour:
- Reset values: state=IDLE, last_gnt=1 (port 0 wins the first tie), all gnt/rvalid/err=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, RMW_WR.
- IDLE arbitration:
  - One request only: grant it.
  - Both requesting with RR_EN=1: grant the port not equal to last_gnt.
  - Both requesting with RR_EN=0: grant port 0.
  - last_gnt updates on every grant.
  - gnt is combinational in the same cycle as req. mem_addr is driven from the granted port.
- Load:
  - Capture mem_rdata at the grant edge. Select the byte (addr[1:0]) or half (addr[1]) lane, then extend per uns.
  - rvalid and rdata are registered and appear the following cycle. Latency is 1.
- Word store: mem_we=1 in the grant cycle with mem_wdata=wdata. rvalid follows the next cycle.
- Sub-word store:
  - Grant cycle: mem_we=0. Latch mem_rdata, the address, wdata, size and port. Go to RMW_WR.
  - RMW_WR: mem_we=1. mem_wdata is the latched word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. rvalid pulses this cycle+1. Return to IDLE.
  - No grants are issued while in RMW_WR. Requests stay pending.
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0):
  - Grant it, suppress mem_we, do not enter RMW.
  - Next cycle: rvalid=1, err=1, rdata=0.
- A port may re-request in the cycle its rvalid is high. Back-to-back loads sustain 1 per cycle.
- Only one gnt may be high in any cycle. rvalid is a single-cycle pulse.
- Reset asserted mid-RMW: abort immediately, no write is issued, all outputs return to reset values.
- Address bits above ADDR_W+1 are ignored (wrap-around).

Decomposition:
- Shared package: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), FSM state encodings, lane-select constants.
- One sub-module, dm_lane_unit (combinational):
  - Load extraction and extension: word, addr[1:0], size, uns -> 32-bit result.
  - Store merge: old word, wdata, addr[1:0], size -> merged word.
- Instantiated once for load and once for merge.

Test Plan:
- m0 store word 0x12345678 @0x10, then m0 load word @0x10 -> mem_we one cycle at mem_addr=4; rvalid next cycle, rdata=0x12345678.
- m0 store byte 0xAB @0x13 over word 0x12345678 -> gnt, then mem_we one cycle later with mem_wdata=0xAB345678; no gnt in the RMW cycle; rvalid on the following cycle.
- Word 0x8000FF80 @0x20; load byte signed @0x20 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load half signed @0x22 -> 0xFFFF8000.
- m0 and m1 request continuously (RR_EN=1) -> gnts alternate m0, m1, m0, ...; with RR_EN=0 only m0 is granted while m0_req=1.
- m1 load half @0x21 -> gnt, next cycle m1_rvalid=1, m1_err=1, m1_rdata=0; mem_we stays 0.
- Assert reset during RMW_WR of a store byte @0x30 -> no mem_we; word @0x30 is unchanged; all outputs are 0 and state is IDLE.
